// File: rtl/l1_readout_queue_if.sv
// Handshake bundle between the L1 command detector, the readout queue and the readout controller.
// The master side drives triggers, pops and overflow clears; the slave side is the queue itself.
interface l1_readout_queue_if #(
  parameter int ID_W      = 8,
  parameter int PTR_W     = 3,
  parameter int OVF_CNT_W = 8
);
  logic                 L1detAck;
  logic [ID_W-1:0]      L1L0ID;
  logic                 RdReq;
  logic [ID_W-1:0]      RdID;
  logic                 RdAck;
  logic                 Full;
  logic                 Empty;
  logic [PTR_W:0]       Count;
  logic                 Overflow;
  logic [OVF_CNT_W-1:0] OverflowCnt;
  logic                 ClrOverflow;

  modport master (
    output L1detAck, L1L0ID, RdAck, ClrOverflow,
    input  RdReq, RdID, Full, Empty, Count, Overflow, OverflowCnt
  );

  modport slave (
    input  L1detAck, L1L0ID, RdAck, ClrOverflow,
    output RdReq, RdID, Full, Empty, Count, Overflow, OverflowCnt
  );
endinterface

// File: rtl/l1_readout_queue.sv
// FIFO of L1L0IDs captured on each L1detAck strobe, popped by the readout controller via RdReq/RdAck.
// Triggers arriving while full (and not popped that cycle) are dropped, flagged and counted.
module l1_readout_queue #(
  parameter int ID_W      = 8,
  parameter int DEPTH     = 8,
  parameter int PTR_W     = 3,
  parameter int OVF_CNT_W = 8
) (
  input  logic                clk,
  input  logic                Reset,
  l1_readout_queue_if.slave   bus
);

  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  function automatic logic [OVF_CNT_W-1:0] sat_inc(input logic [OVF_CNT_W-1:0] v);
    return (&v) ? v : v + OVF_CNT_W'(1);
  endfunction

  logic [ID_W-1:0]      mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

  logic full, empty, push, pop, drop;

  // Handshake decode: everything is judged on the registered (pre-edge) occupancy.
  always_comb begin
    full  = (count_q == FULL_CNT);
    empty = (count_q == '0);
    pop   = bus.RdAck & ~empty;
    push  = bus.L1detAck & (~full | pop);
    drop  = bus.L1detAck & full & ~pop;
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    ovf_cnt_d = ovf_cnt_q;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A drop in the same cycle as a clear restarts the tally at one.
    if (drop) begin
      ovf_d     = 1'b1;
      ovf_cnt_d = bus.ClrOverflow ? OVF_CNT_W'(1) : sat_inc(ovf_cnt_q);
    end else if (bus.ClrOverflow) begin
      ovf_d     = 1'b0;
      ovf_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      ovf_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  // Storage is never cleared; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push && !Reset) mem_q[wr_ptr_q] <= bus.L1L0ID;
  end

  assign bus.RdReq       = ~empty;
  assign bus.RdID        = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.Full        = full;
  assign bus.Empty       = empty;
  assign bus.Count       = count_q;
  assign bus.Overflow    = ovf_q;
  assign bus.OverflowCnt = ovf_cnt_q;

endmodule
